// File: rtl/rv16_pkg.sv
// Shared opcode encoding and field widths for the rv16 issue stage and its FU demuxes.
package rv16_pkg;
   localparam int OPC_W = 4;
   localparam int RD_W  = 3;

   typedef enum logic [OPC_W-1:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_MUL = 4'd2,
      OP_DIV = 4'd3,
      OP_XOR = 4'd4,
      OP_AND = 4'd5,
      OP_OR  = 4'd6,
      OP_NOP = 4'hF
   } opcode_e;

   function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
      return op <= OP_OR;
   endfunction
endpackage

// File: rtl/rv16_fu_issue_if.sv
// Decode-to-issue handshake plus issue outputs toward the rs1/rs2 FU demuxes.
interface rv16_fu_issue_if import rv16_pkg::*; #(parameter int DATA = 4) ();
   logic             flush;
   logic             dec_valid;
   logic             dec_ready;
   logic [OPC_W-1:0] dec_opcode;
   logic [DATA-1:0]  dec_rs1;
   logic [DATA-1:0]  dec_rs2;
   logic [RD_W-1:0]  dec_rd;
   logic             iss_fire;
   logic [OPC_W-1:0] iss_opcode;
   logic [DATA-1:0]  iss_rs1;
   logic [DATA-1:0]  iss_rs2;
   logic [RD_W-1:0]  iss_rd;
   logic             mul_busy;
   logic             div_busy;
   logic             illegal_op;

   modport master (
      output flush, dec_valid, dec_opcode, dec_rs1, dec_rs2, dec_rd,
      input  dec_ready, iss_fire, iss_opcode, iss_rs1, iss_rs2, iss_rd,
      input  mul_busy, div_busy, illegal_op
   );

   modport slave (
      input  flush, dec_valid, dec_opcode, dec_rs1, dec_rs2, dec_rd,
      output dec_ready, iss_fire, iss_opcode, iss_rs1, iss_rs2, iss_rd,
      output mul_busy, div_busy, illegal_op
   );
endinterface

// File: rtl/rv16_fu_busy_ctr.sv
// Busy window of one multi-cycle FU: reloads to LAT-1 on start, counts down to 0.
// A start at cycle t lets the next start happen at t+LAT at the earliest.
module rv16_fu_busy_ctr #(
   parameter int LAT = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy
);
   localparam int CW = $clog2(LAT + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (start) begin
         r_cnt <= CW'(LAT - 1);
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign busy = (r_cnt != '0);
endmodule

// File: rtl/rv16_fu_issue.sv
// Single-entry in-order issue stage: holds one decoded op, fires it for one cycle once its
// FU is free, and drives OP_NOP with zeroed operands on every other cycle.
module rv16_fu_issue import rv16_pkg::*; #(
   parameter int DATA    = 4,
   parameter int MUL_LAT = 3,
   parameter int DIV_LAT = 6
) (
   input logic             clk,
   input logic             rst,
   rv16_fu_issue_if.slave  bus
);
   logic             r_hv;
   logic [OPC_W-1:0] r_op;
   logic [DATA-1:0]  r_rs1;
   logic [DATA-1:0]  r_rs2;
   logic [RD_W-1:0]  r_rd;
   logic             r_illegal;

   logic w_mul_busy;
   logic w_div_busy;
   logic w_unit_free;
   logic w_fire;
   logic w_ready;
   logic w_accept;
   logic w_legal;

   always_comb begin
      w_unit_free = 1'b1;
      if (r_op == OP_MUL) w_unit_free = ~w_mul_busy;
      else if (r_op == OP_DIV) w_unit_free = ~w_div_busy;
   end

   assign w_fire   = r_hv & w_unit_free & ~bus.flush;
   assign w_ready  = ~bus.flush & (~r_hv | w_fire);
   assign w_accept = bus.dec_valid & w_ready;
   assign w_legal  = is_legal_op(bus.dec_opcode);

   // Illegal opcodes are consumed from decode but never enter the hold register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hv      <= 1'b0;
         r_op      <= '0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_rd      <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= w_accept & ~w_legal;
         if (bus.flush) begin
            r_hv <= 1'b0;
         end else if (w_accept) begin
            r_hv <= w_legal;
            if (w_legal) begin
               r_op  <= bus.dec_opcode;
               r_rs1 <= bus.dec_rs1;
               r_rs2 <= bus.dec_rs2;
               r_rd  <= bus.dec_rd;
            end
         end else if (w_fire) begin
            r_hv <= 1'b0;
         end
      end
   end

   rv16_fu_busy_ctr #(.LAT(MUL_LAT)) u_mul_ctr (
      .clk   (clk),
      .rst   (rst),
      .start (w_fire & (r_op == OP_MUL)),
      .busy  (w_mul_busy)
   );

   rv16_fu_busy_ctr #(.LAT(DIV_LAT)) u_div_ctr (
      .clk   (clk),
      .rst   (rst),
      .start (w_fire & (r_op == OP_DIV)),
      .busy  (w_div_busy)
   );

   assign bus.dec_ready  = w_ready;
   assign bus.iss_fire   = w_fire;
   assign bus.iss_opcode = w_fire ? r_op  : OP_NOP;
   assign bus.iss_rs1    = w_fire ? r_rs1 : '0;
   assign bus.iss_rs2    = w_fire ? r_rs2 : '0;
   assign bus.iss_rd     = w_fire ? r_rd  : '0;
   assign bus.mul_busy   = w_mul_busy;
   assign bus.div_busy   = w_div_busy;
   assign bus.illegal_op = r_illegal;
endmodule
